// File: rtl/mips_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The core side drives the operation request and MTHI/MTLO writes; the unit
// returns the architectural HI/LO registers and its status flags.
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start__i;
  logic [1:0]       op__i;
  logic [WIDTH-1:0] dataA__i;
  logic [WIDTH-1:0] dataB__i;
  logic             cancel__i;
  logic             hiWrite__i;
  logic             loWrite__i;
  logic [WIDTH-1:0] mtData__i;
  logic [WIDTH-1:0] hi__o;
  logic [WIDTH-1:0] lo__o;
  logic             busy__o;
  logic             done__o;
  logic             divZero__o;

  modport master (
    output start__i, op__i, dataA__i, dataB__i, cancel__i,
    output hiWrite__i, loWrite__i, mtData__i,
    input  hi__o, lo__o, busy__o, done__o, divZero__o
  );

  modport slave (
    input  start__i, op__i, dataA__i, dataB__i, cancel__i,
    input  hiWrite__i, loWrite__i, mtData__i,
    output hi__o, lo__o, busy__o, done__o, divZero__o
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle for WIDTH cycles, then one sign-fixup cycle that commits HI/LO.
// Operands are reduced to magnitudes on entry; acc_q holds the upper half
// (partial product high / partial remainder) and qr_q the lower half
// (multiplier bits shifting out / dividend bits shifting out, quotient in).
module mips_muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic             clock__i,
  input logic             reset_n__i,
  mips_muldiv_unit_if.slave bus
);

  localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] qr_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             is_div_q;
  logic             neg_a_q;
  logic             neg_b_q;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_pulse_q;

  logic             is_signed_s;
  logic             neg_a_s;
  logic             neg_b_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] step_acc_d;
  logic [WIDTH-1:0] step_qr_d;
  logic [WIDTH:0]   div_shift_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_neg_s;
  logic [WIDTH-1:0] fix_hi_d;
  logic [WIDTH-1:0] fix_lo_d;

  // Operand entry: decide signedness and reduce operands to magnitudes.
  always_comb begin
    is_signed_s = SIGNED_EN && !bus.op__i[0];
    neg_a_s     = is_signed_s && bus.dataA__i[WIDTH-1];
    neg_b_s     = is_signed_s && bus.dataB__i[WIDTH-1];
    if (neg_a_s) begin
      mag_a_s = ZERO_W - bus.dataA__i;
    end else begin
      mag_a_s = bus.dataA__i;
    end
    if (neg_b_s) begin
      mag_b_s = ZERO_W - bus.dataB__i;
    end else begin
      mag_b_s = bus.dataB__i;
    end
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q};
    div_shift_s = {acc_q, qr_q[WIDTH-1]};
    step_acc_d  = acc_q;
    step_qr_d   = qr_q;
    if (is_div_q) begin
      // Remainder stays below the divisor, so the difference fits WIDTH bits.
      if (div_shift_s >= {1'b0, opb_q}) begin
        step_acc_d = div_shift_s[WIDTH-1:0] - opb_q;
        step_qr_d  = {qr_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc_d = div_shift_s[WIDTH-1:0];
        step_qr_d  = {qr_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (qr_q[0]) begin
        mul_sum_s = {1'b0, acc_q} + {1'b0, opb_q};
      end else begin
        mul_sum_s = {1'b0, acc_q};
      end
      step_acc_d = mul_sum_s[WIDTH:1];
      step_qr_d  = {mul_sum_s[0], qr_q[WIDTH-1:1]};
    end
  end

  // Sign correction of the magnitude result; divide-by-zero gets fixed values.
  always_comb begin
    prod_s     = {acc_q, qr_q};
    prod_neg_s = {(2*WIDTH){1'b0}} - prod_s;
    fix_hi_d   = acc_q;
    fix_lo_d   = qr_q;
    if (is_div_q) begin
      // Remainder takes the dividend's sign; with a zero divisor the
      // remainder path has shifted the whole dividend magnitude into acc_q,
      // so re-signing it restores the dividend as latched.
      if (neg_a_q) begin
        fix_hi_d = ZERO_W - acc_q;
      end else begin
        fix_hi_d = acc_q;
      end
      if (dz_q) begin
        fix_lo_d = ONES_W;
      end else if (neg_a_q ^ neg_b_q) begin
        fix_lo_d = ZERO_W - qr_q;
      end else begin
        fix_lo_d = qr_q;
      end
    end else begin
      if (neg_a_q ^ neg_b_q) begin
        {fix_hi_d, fix_lo_d} = prod_neg_s;
      end else begin
        {fix_hi_d, fix_lo_d} = prod_s;
      end
    end
  end

  // Control FSM with datapath registers, HI/LO and registered status outputs.
  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      acc_q      <= ZERO_W;
      qr_q       <= ZERO_W;
      opb_q      <= ZERO_W;
      hi_q       <= ZERO_W;
      lo_q       <= ZERO_W;
      is_div_q   <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.hiWrite__i) begin
            hi_q <= bus.mtData__i;
          end
          if (bus.loWrite__i) begin
            lo_q <= bus.mtData__i;
          end
          if (bus.start__i && !bus.cancel__i) begin
            state_q  <= ST_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= ZERO_W;
            qr_q     <= mag_a_s;
            opb_q    <= mag_b_s;
            is_div_q <= bus.op__i[1];
            neg_a_q  <= neg_a_s;
            neg_b_q  <= neg_b_s;
            dz_q     <= bus.op__i[1] && (bus.dataB__i == ZERO_W);
          end
        end
        ST_RUN: begin
          if (bus.cancel__i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
          end else begin
            acc_q <= step_acc_d;
            qr_q  <= step_qr_d;
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_FIXUP;
              cnt_q   <= {CNT_W{1'b0}};
            end else begin
              cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_FIXUP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (!bus.cancel__i) begin
            hi_q       <= fix_hi_d;
            lo_q       <= fix_lo_d;
            done_q     <= 1'b1;
            dz_pulse_q <= dz_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.hi__o      = hi_q;
  assign bus.lo__o      = lo_q;
  assign bus.busy__o    = busy_q;
  assign bus.done__o    = done_q;
  assign bus.divZero__o = dz_pulse_q;

endmodule
